// File: rtl/correlation_vacc.sv
// Integrates two auto powers and the complex cross-correlation over acc_len spectra,
// holding one running sum per channel in four block RAMs and streaming out the last spectrum.
module correlation_vacc #(
  parameter int DIN_WIDTH     = 37,
  parameter int DOUT_WIDTH    = 64,
  parameter int VECTOR_LEN    = 64,
  parameter int ACC_LEN_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIN_WIDTH-1:0]          din1_pow,
  input  logic [DIN_WIDTH-1:0]          din2_pow,
  input  logic [DIN_WIDTH-1:0]          corr_re,
  input  logic [DIN_WIDTH-1:0]          corr_im,
  input  logic                          din_valid,
  input  logic                          sync,
  input  logic [ACC_LEN_WIDTH-1:0]      acc_len,
  output logic [DOUT_WIDTH-1:0]         dout_pow1,
  output logic [DOUT_WIDTH-1:0]         dout_pow2,
  output logic [DOUT_WIDTH-1:0]         dout_re,
  output logic [DOUT_WIDTH-1:0]         dout_im,
  output logic [$clog2(VECTOR_LEN)-1:0] dout_addr,
  output logic                          dout_valid,
  output logic                          dout_last,
  output logic                          sync_err
);

  localparam int AW = $clog2(VECTOR_LEN);
  localparam logic [AW-1:0] LAST_CH = AW'(VECTOR_LEN - 1);

  typedef enum logic {WAIT_SYNC, RUN} state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            ch_cnt;
  logic [ACC_LEN_WIDTH-1:0] spec_cnt;
  logic [ACC_LEN_WIDTH-1:0] acc_len_r;

  logic                     sync_in, restart, misalign, in_fire, new_int;
  logic                     cur_first, cur_last;
  logic [AW-1:0]            cur_ch;
  logic [ACC_LEN_WIDTH-1:0] cur_spec, cur_len, acc_len_eff;
  logic [DOUT_WIDTH-1:0]    ext [4];

  logic                     s1_valid, s1_first, s1_last;
  logic [AW-1:0]            s1_addr;
  logic [DOUT_WIDTH-1:0]    s1_in [4];
  logic [DOUT_WIDTH-1:0]    sum [4];

  // A sync seen off channel 0 (or the first sync) restarts the integration on this very sample.
  always_comb begin
    sync_in     = din_valid & sync;
    restart     = sync_in & ((state_q == WAIT_SYNC) | (ch_cnt != '0));
    misalign    = sync_in & (state_q == RUN) & (ch_cnt != '0);
    in_fire     = din_valid & ((state_q == RUN) | sync);
    cur_ch      = restart ? '0 : ch_cnt;
    cur_spec    = restart ? '0 : spec_cnt;
    new_int     = (cur_ch == '0) & (cur_spec == '0);
    acc_len_eff = (acc_len == '0) ? ACC_LEN_WIDTH'(1) : acc_len;
    cur_len     = new_int ? acc_len_eff : acc_len_r;
    cur_first   = (cur_spec == '0);
    cur_last    = (cur_spec == cur_len - 1'b1);
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == WAIT_SYNC) && sync_in) begin
      state_d = RUN;
    end
  end

  always_comb begin
    ext[0] = DOUT_WIDTH'(din1_pow);
    ext[1] = DOUT_WIDTH'(din2_pow);
    ext[2] = DOUT_WIDTH'(signed'(corr_re));
    ext[3] = DOUT_WIDTH'(signed'(corr_im));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_SYNC;
      ch_cnt    <= '0;
      spec_cnt  <= '0;
      acc_len_r <= ACC_LEN_WIDTH'(1);
      sync_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (misalign) begin
        sync_err <= 1'b1;
      end
      if (in_fire) begin
        ch_cnt <= cur_ch + 1'b1;
        if (cur_ch == LAST_CH) begin
          spec_cnt <= cur_last ? '0 : cur_spec + 1'b1;
        end else begin
          spec_cnt <= cur_spec;
        end
        if (new_int) begin
          acc_len_r <= acc_len_eff;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_addr  <= '0;
      for (int unsigned q = 0; q < 4; q++) begin
        s1_in[q] <= '0;
      end
    end else begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_first <= cur_first;
        s1_last  <= cur_last;
        s1_addr  <= cur_ch;
        for (int unsigned q = 0; q < 4; q++) begin
          s1_in[q] <= ext[q];
        end
      end
    end
  end

  // Read at the input cycle, add and write back one cycle later; VECTOR_LEN >= 4 keeps RMWs apart.
  for (genvar q = 0; q < 4; q++) begin : g_lane
    logic [DOUT_WIDTH-1:0] mem [VECTOR_LEN];
    logic [DOUT_WIDTH-1:0] rd;

    always_ff @(posedge clk) begin
      if (in_fire) begin
        rd <= mem[cur_ch];
      end
      if (s1_valid) begin
        mem[s1_addr] <= sum[q];
      end
    end

    assign sum[q] = s1_first ? s1_in[q] : rd + s1_in[q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      dout_addr  <= '0;
      dout_pow1  <= '0;
      dout_pow2  <= '0;
      dout_re    <= '0;
      dout_im    <= '0;
    end else begin
      dout_valid <= s1_valid & s1_last;
      dout_last  <= s1_valid & s1_last & (s1_addr == LAST_CH);
      if (s1_valid && s1_last) begin
        dout_addr <= s1_addr;
        dout_pow1 <= sum[0];
        dout_pow2 <= sum[1];
        dout_re   <= sum[2];
        dout_im   <= sum[3];
      end
    end
  end

endmodule

// File: tb/tb_correlation_vacc.sv
// Directed, table-driven bench for correlation_vacc with small widths so wrap-around is reachable.
module tb_correlation_vacc;

  localparam int IW = 8;
  localparam int DW = 9;
  localparam int VL = 4;
  localparam int LW = 8;
  localparam int AW = $clog2(VL);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] din1_pow, din2_pow, corr_re, corr_im;
  logic          din_valid, sync;
  logic [LW-1:0] acc_len;
  logic [DW-1:0] dout_pow1, dout_pow2, dout_re, dout_im;
  logic [AW-1:0] dout_addr;
  logic          dout_valid, dout_last, sync_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic v;
    logic s;
    int   len;
    int   p1, p2, re, im;
    logic edv;
    int   e1, e2, ere, eim;
    int   eaddr;
  } vec_t;

  vec_t tbl[$];

  correlation_vacc #(
    .DIN_WIDTH(IW),
    .DOUT_WIDTH(DW),
    .VECTOR_LEN(VL),
    .ACC_LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din1_pow(din1_pow),
    .din2_pow(din2_pow),
    .corr_re(corr_re),
    .corr_im(corr_im),
    .din_valid(din_valid),
    .sync(sync),
    .acc_len(acc_len),
    .dout_pow1(dout_pow1),
    .dout_pow2(dout_pow2),
    .dout_re(dout_re),
    .dout_im(dout_im),
    .dout_addr(dout_addr),
    .dout_valid(dout_valid),
    .dout_last(dout_last),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", nm, $time, act, act, exp, exp);
    end
  endtask

  function automatic void push(logic v, logic s, int len, int p1, int p2, int re, int im,
                               logic edv, int e1, int e2, int ere, int eim, int eaddr);
    vec_t r;
    r.v = v; r.s = s; r.len = len;
    r.p1 = p1; r.p2 = p2; r.re = re; r.im = im;
    r.edv = edv; r.e1 = e1; r.e2 = e2; r.ere = ere; r.eim = eim; r.eaddr = eaddr;
    tbl.push_back(r);
  endfunction

  task automatic apply(input vec_t r);
    din_valid = r.v;
    sync      = r.s;
    acc_len   = LW'(r.len);
    din1_pow  = IW'(r.p1);
    din2_pow  = IW'(r.p2);
    corr_re   = IW'(r.re);
    corr_im   = IW'(r.im);
  endtask

  task automatic check_rec(input vec_t r);
    chk("dout_valid", DW'(dout_valid), DW'(r.edv));
    if (r.edv) begin
      chk("dout_pow1", dout_pow1, DW'(r.e1));
      chk("dout_pow2", dout_pow2, DW'(r.e2));
      chk("dout_re",   dout_re,   DW'(r.ere));
      chk("dout_im",   dout_im,   DW'(r.eim));
      chk("dout_addr", DW'(dout_addr), DW'(r.eaddr));
      chk("dout_last", DW'(dout_last), DW'(r.eaddr == VL - 1));
    end
  endtask

  // Output for the entry applied two iterations earlier is visible now.
  task automatic run_table();
    vec_t idle;
    idle = '{v: 1'b0, s: 1'b0, len: 1, p1: 0, p2: 0, re: 0, im: 0,
             edv: 1'b0, e1: 0, e2: 0, ere: 0, eim: 0, eaddr: 0};
    for (int i = 0; i < tbl.size() + 2; i++) begin
      @(posedge clk); #1;
      if (i >= 2) check_rec(tbl[i-2]);
      if (i < tbl.size()) apply(tbl[i]);
      else apply(idle);
    end
    tbl.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    din_valid = 1'b0; sync = 1'b0; acc_len = '0;
    din1_pow = '0; din2_pow = '0; corr_re = '0; corr_im = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst dout_valid", DW'(dout_valid), '0);
    chk("rst dout_last",  DW'(dout_last),  '0);
    chk("rst dout_addr",  DW'(dout_addr),  '0);
    chk("rst dout_pow1",  dout_pow1, '0);
    chk("rst dout_re",    dout_re,   '0);
    chk("rst sync_err",   DW'(sync_err),   '0);
    rst_n = 1'b1;

    // Samples before the first sync are ignored.
    for (int k = 0; k < 3; k++) push(1, 0, 3, 99, 99, 99, 99, 0, 0, 0, 0, 0, 0);

    // Basic integration, acc_len = 3.
    for (int s = 0; s < 6; s++)
      for (int ch = 0; ch < VL; ch++)
        push(1, (s == 0 && ch == 0), 3, 5, 7, -2, 3, (s % 3 == 2), 15, 21, -6, 9, ch);

    // acc_len = 0 then acc_len = 1: every spectrum passes straight through.
    for (int len = 0; len < 2; len++)
      for (int s = 0; s < 3; s++)
        for (int ch = 0; ch < VL; ch++)
          push(1, (s == 0 && ch == 0), len, ch, ch + 1, -ch, 2 * ch,
               1, ch, ch + 1, -ch, 2 * ch, ch);

    // acc_len 2 -> 4 during spectrum 1: first integration sums 2, the next sums 4.
    for (int s = 0; s < 6; s++)
      for (int ch = 0; ch < VL; ch++)
        push(1, (s == 0 && ch == 0), ((s == 0) || (s == 1 && ch == 0)) ? 2 : 4,
             s + 1, 10, -3, 4, (s == 1 || s == 5),
             (s == 1) ? 3 : 18, (s == 1) ? 20 : 40, (s == 1) ? -6 : -12, (s == 1) ? 8 : 16, ch);
    run_table();
    chk("sync_err after aligned syncs", DW'(sync_err), '0);

    // Misaligned sync at channel 2 of spectrum 1; aborted data must not leak into the new sum.
    for (int k = 0; k < 6; k++) push(1, (k == 0), 3, 50, 50, 50, 50, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      push(1, (k == 0), 2, 3, 4, 5, -6, (k >= 4), 6, 8, 10, -12, k % VL);
    run_table();
    chk("sync_err after misaligned sync", DW'(sync_err), 1);

    // Random gaps with extreme values; sums wrap modulo 2^9.
    for (int n = 0; n < 2; n++)
      for (int s = 0; s < 4; s++)
        for (int ch = 0; ch < VL; ch++) begin
          int g;
          g = $urandom_range(0, 2);
          for (int k = 0; k < g; k++)
            push(0, 1'($urandom_range(0, 1)), 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
          if (n == 0)
            push(1, (s == 0 && ch == 0), 4, 255, 200, 127, -128, (s == 3), 508, 288, 508, 0, ch);
          else
            push(1, (s == 0 && ch == 0), 4, 1, 128, -128, 127, (s == 3), 4, 0, 0, 508, ch);
        end
    run_table();

    // Reset during a last spectrum (acc_len = 1).
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      din_valid = 1'b1; sync = (k == 0); acc_len = 1;
      din1_pow = 20; din2_pow = 21; corr_re = 22; corr_im = 23;
    end
    chk("pre-reset dout_valid", DW'(dout_valid), 1);
    chk("pre-reset dout_pow1", dout_pow1, 20);
    #3 rst_n = 1'b0;
    #1;
    chk("reset dout_valid", DW'(dout_valid), '0);
    chk("reset dout_pow1",  dout_pow1, '0);
    chk("reset sync_err",   DW'(sync_err), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sync = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("post-reset no output", DW'(dout_valid), '0);
    end

    // First integration after reset must ignore stale RAM contents.
    for (int k = 0; k < 8; k++)
      push(1, (k == 0), 2, 9, 1, -7, 0, (k >= 4), 18, 2, -14, 0, k % VL);
    run_table();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
